// File: rtl/branch_predict_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_resolve_unit
//
// Branch prediction and EX-stage resolution for the pipeline.
//  - A direct-mapped BTB with 2-bit saturating counters supplies a next-PC
//    prediction to IF (combinational lookup).
//  - Branches and jumps are resolved in EX from the ALU flags. A
//    misprediction produces a registered redirect/flush pulse that lasts
//    one cycle.
//  - A saturating counter records mispredictions for performance monitoring.
//
// Ports:
//   CLK, RESET        clock (rising edge); asynchronous active-low reset
//   IF_PC             fetch PC to look up
//   PRED_TAKEN        predicted taken for IF_PC (combinational)
//   PRED_TARGET       predicted next PC for IF_PC (combinational)
//   EX_VALID          EX holds a real instruction
//   EX_PC             PC of the EX instruction
//   EX_BRANCH         EX instruction is a conditional branch
//   EX_JUMP           EX instruction is JAL/JALR
//   EX_FUNC3          branch funct3
//   ZERO/SIGN/UNSIGNED  ALU flags: zero, signed less-than, unsigned less-than
//   BRANCH_ADDR       computed branch target
//   JUMP_ADDR         computed jump target
//   EX_PRED_TAKEN     prediction carried down the pipe with the instruction
//   EX_PRED_TARGET    predicted target carried down the pipe
//   PC_MUX_CONTROL    registered; select REDIRECT_ADDR as the next PC
//   REDIRECT_ADDR     registered corrected PC (holds when not redirecting)
//   REG_FLUSH         registered; flush the IF/ID and ID/EX registers
//   MISPREDICT_COUNT  saturating misprediction count
// ---------------------------------------------------------------------------
module branch_predict_resolve_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [XLEN-1:0]   IF_PC,
   output logic              PRED_TAKEN,
   output logic [XLEN-1:0]   PRED_TARGET,
   input  logic              EX_VALID,
   input  logic [XLEN-1:0]   EX_PC,
   input  logic              EX_BRANCH,
   input  logic              EX_JUMP,
   input  logic [2:0]        EX_FUNC3,
   input  logic              ZERO,
   input  logic              SIGN,
   input  logic              UNSIGNED,
   input  logic [XLEN-1:0]   BRANCH_ADDR,
   input  logic [XLEN-1:0]   JUMP_ADDR,
   input  logic              EX_PRED_TAKEN,
   input  logic [XLEN-1:0]   EX_PRED_TARGET,
   output logic              PC_MUX_CONTROL,
   output logic [XLEN-1:0]   REDIRECT_ADDR,
   output logic              REG_FLUSH,
   output logic [CNT_W-1:0]  MISPREDICT_COUNT
);

   localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX - 2;

   // BTB storage
   logic              btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]   btb_target [BTB_ENTRIES];
   logic [1:0]        btb_ctr    [BTB_ENTRIES];

   // Registered outputs
   logic              pc_mux_q;
   logic              flush_q;
   logic [XLEN-1:0]   redirect_q;
   logic [CNT_W-1:0]  count_q;

   // Lookup
   logic [IDX-1:0]    if_idx;
   logic [TAG_W-1:0]  if_tag;
   logic              if_hit;
   logic              pred_taken;

   // Resolution
   logic [IDX-1:0]    ex_idx;
   logic [TAG_W-1:0]  ex_tag;
   logic              ex_hit;
   logic              cond;
   logic              res;
   logic              taken;
   logic [XLEN-1:0]   tgt;
   logic              mispredict;

   // BTB write port
   logic              btb_we;
   logic              btb_tgt_we;
   logic [1:0]        ctr_nxt;

   // ---------------------------------------------------------------------
   // Combinational lookup; reads the array contents before this edge's write
   // ---------------------------------------------------------------------
   assign if_idx      = IF_PC[IDX+1:2];
   assign if_tag      = IF_PC[XLEN-1:IDX+2];
   assign if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
   assign pred_taken  = if_hit && btb_ctr[if_idx][1];
   assign PRED_TAKEN  = pred_taken;
   assign PRED_TARGET = pred_taken ? btb_target[if_idx] : IF_PC + XLEN'(4);

   // ---------------------------------------------------------------------
   // Branch condition decode
   // ---------------------------------------------------------------------
   always_comb begin
      cond = 1'b0;
      unique case (EX_FUNC3)
         3'b000:  cond = ZERO;
         3'b001:  cond = ~ZERO;
         3'b100:  cond = SIGN;
         3'b101:  cond = ~SIGN;
         3'b110:  cond = UNSIGNED;
         3'b111:  cond = ~UNSIGNED;
         default: cond = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Resolution. While the flush pulse is high the EX stage holds a
   // wrong-path instruction, so nothing is resolved in that cycle.
   // ---------------------------------------------------------------------
   assign ex_idx     = EX_PC[IDX+1:2];
   assign ex_tag     = EX_PC[XLEN-1:IDX+2];
   assign ex_hit     = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
   assign res        = EX_VALID && !flush_q && (EX_BRANCH || EX_JUMP);
   assign taken      = EX_JUMP || (EX_BRANCH && cond);
   assign tgt        = EX_JUMP ? JUMP_ADDR : BRANCH_ADDR;
   assign mispredict = (taken != EX_PRED_TAKEN) ||
                       (taken && (EX_PRED_TARGET != tgt));

   // ---------------------------------------------------------------------
   // BTB update decision
   // ---------------------------------------------------------------------
   always_comb begin
      btb_we     = 1'b0;
      btb_tgt_we = 1'b0;
      ctr_nxt    = btb_ctr[ex_idx];
      if (res) begin
         if (ex_hit) begin
            btb_we = 1'b1;
            if (EX_JUMP) begin
               ctr_nxt    = 2'b11;
               btb_tgt_we = 1'b1;
            end else if (taken) begin
               ctr_nxt    = (btb_ctr[ex_idx] == 2'b11) ? 2'b11
                                                       : btb_ctr[ex_idx] + 2'd1;
               btb_tgt_we = 1'b1;
            end else begin
               ctr_nxt    = (btb_ctr[ex_idx] == 2'b00) ? 2'b00
                                                       : btb_ctr[ex_idx] - 2'd1;
            end
         end else if (taken) begin
            // Allocate, replacing whatever aliased entry was there
            btb_we     = 1'b1;
            btb_tgt_we = 1'b1;
            ctr_nxt    = EX_JUMP ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'b01;
         end
      end else if (btb_we) begin
         btb_valid[ex_idx] <= 1'b1;
         btb_tag[ex_idx]   <= ex_tag;
         btb_ctr[ex_idx]   <= ctr_nxt;
         if (btb_tgt_we) begin
            btb_target[ex_idx] <= tgt;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Redirect pulse, redirect address and misprediction counter
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc_mux_q   <= 1'b0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         count_q    <= '0;
      end else begin
         pc_mux_q <= res && mispredict;
         flush_q  <= res && mispredict;
         if (res && mispredict) begin
            redirect_q <= taken ? tgt : EX_PC + XLEN'(4);
            if (count_q != '1) begin
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

   assign PC_MUX_CONTROL   = pc_mux_q;
   assign REG_FLUSH        = flush_q;
   assign REDIRECT_ADDR    = redirect_q;
   assign MISPREDICT_COUNT = count_q;

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_resolve_unit
//
// Directed, table-driven bench. Each table row is one clock cycle: the EX
// and IF inputs are driven, the combinational prediction is compared before
// the edge, and the registered outputs are compared just after the edge.
// A short hand-written sequence covers reset asserted mid-pulse.
// The counter is narrowed to 3 bits so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_branch_predict_resolve_unit;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NENT = 16;
   localparam int unsigned CW   = 3;

   logic            clk;
   logic            rst_n;
   logic [31:0]     if_pc;
   logic            pred_taken;
   logic [31:0]     pred_target;
   logic            ex_valid;
   logic [31:0]     ex_pc;
   logic            ex_branch;
   logic            ex_jump;
   logic [2:0]      ex_func3;
   logic            zero;
   logic            sign;
   logic            uns;
   logic [31:0]     branch_addr;
   logic [31:0]     jump_addr;
   logic            ex_pred_taken;
   logic [31:0]     ex_pred_target;
   logic            pc_mux;
   logic [31:0]     redirect_addr;
   logic            flush;
   logic [CW-1:0]   count;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   branch_predict_resolve_unit #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (NENT),
      .CNT_W       (CW)
   ) dut (
      .CLK              (clk),
      .RESET            (rst_n),
      .IF_PC            (if_pc),
      .PRED_TAKEN       (pred_taken),
      .PRED_TARGET      (pred_target),
      .EX_VALID         (ex_valid),
      .EX_PC            (ex_pc),
      .EX_BRANCH        (ex_branch),
      .EX_JUMP          (ex_jump),
      .EX_FUNC3         (ex_func3),
      .ZERO             (zero),
      .SIGN             (sign),
      .UNSIGNED         (uns),
      .BRANCH_ADDR      (branch_addr),
      .JUMP_ADDR        (jump_addr),
      .EX_PRED_TAKEN    (ex_pred_taken),
      .EX_PRED_TARGET   (ex_pred_target),
      .PC_MUX_CONTROL   (pc_mux),
      .REDIRECT_ADDR    (redirect_addr),
      .REG_FLUSH        (flush),
      .MISPREDICT_COUNT (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] if_pc;
      logic        valid;
      logic [31:0] ex_pc;
      logic        br;
      logic        jmp;
      logic [2:0]  f3;
      logic        z;
      logic        s;
      logic        u;
      logic [31:0] ba;
      logic [31:0] ja;
      logic        pt;
      logic [31:0] ptg;
      logic        e_pt;
      logic [31:0] e_ptg;
      logic        e_pulse;
      logic [31:0] e_redir;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [31:0] ifpc, logic valid, logic [31:0] expc,
                               logic br, logic jmp, logic [2:0] f3,
                               logic z, logic s, logic u,
                               logic [31:0] ba, logic [31:0] ja,
                               logic pt, logic [31:0] ptg,
                               logic e_pt, logic [31:0] e_ptg,
                               logic e_pulse, logic [31:0] e_redir, int e_cnt);
      vec_t v;
      v.if_pc = ifpc;  v.valid = valid; v.ex_pc = expc;
      v.br = br;       v.jmp = jmp;     v.f3 = f3;
      v.z = z;         v.s = s;         v.u = u;
      v.ba = ba;       v.ja = ja;       v.pt = pt;   v.ptg = ptg;
      v.e_pt = e_pt;   v.e_ptg = e_ptg; v.e_pulse = e_pulse;
      v.e_redir = e_redir;
      v.e_cnt = CW'(e_cnt);
      return v;
   endfunction

   function automatic vec_t idle(logic [31:0] ifpc, logic e_pt, logic [31:0] e_ptg,
                                 logic [31:0] e_redir, int e_cnt);
      return mk(ifpc, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 1'b0, 32'h0, e_pt, e_ptg, 1'b0, e_redir, e_cnt);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      if_pc          = v.if_pc;
      ex_valid       = v.valid;
      ex_pc          = v.ex_pc;
      ex_branch      = v.br;
      ex_jump        = v.jmp;
      ex_func3       = v.f3;
      zero           = v.z;
      sign           = v.s;
      uns            = v.u;
      branch_addr    = v.ba;
      jump_addr      = v.ja;
      ex_pred_taken  = v.pt;
      ex_pred_target = v.ptg;
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0;
      v = idle(32'h100, 1'b0, 32'h104, 32'h0, 0);
      drive(v);

      // --- vector table ---
      // 0: idle lookup after reset
      vecs.push_back(idle(32'h100, 0, 32'h104, 32'h0, 0));
      // 1: BEQ 0x100 taken, predicted not taken -> redirect 0x200, allocate
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 3'b000, 1, 0, 0, 32'h200, 32'h0, 0, 32'h104,
                        0, 32'h104, 1, 32'h200, 1));
      // 2: pulse drops; lookup now hits, counter 10
      vecs.push_back(idle(32'h100, 1, 32'h200, 32'h200, 1));
      // 3: same BEQ not taken, predicted taken -> redirect to fall-through, ctr 10->01
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 3'b000, 0, 0, 0, 32'h200, 32'h0, 1, 32'h200,
                        1, 32'h200, 1, 32'h104, 2));
      // 4: lookup now predicts not taken
      vecs.push_back(idle(32'h100, 0, 32'h104, 32'h104, 2));
      // 5: JAL 0x140 predicted correctly -> no redirect; aliases 0x100, replaces entry
      vecs.push_back(mk(32'h100, 1, 32'h140, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h300, 1, 32'h300,
                        0, 32'h104, 0, 32'h104, 2));
      // 6: 0x100 misses after replacement
      vecs.push_back(idle(32'h100, 0, 32'h104, 32'h104, 2));
      // 7: 0x140 hits with ctr 11
      vecs.push_back(idle(32'h140, 1, 32'h300, 32'h104, 2));
      // 8: JAL 0x140 with wrong predicted target -> redirect 0x300
      vecs.push_back(mk(32'h140, 1, 32'h140, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h300, 1, 32'h2FC,
                        1, 32'h300, 1, 32'h300, 3));
      // 9: tag mismatch at same index
      vecs.push_back(idle(32'h200, 0, 32'h204, 32'h300, 3));
      // 10: BNE taken at 0x20 (index 8) -> redirect 0x400
      vecs.push_back(mk(32'h0, 1, 32'h20, 1, 0, 3'b001, 0, 0, 0, 32'h400, 32'h0, 0, 32'h24,
                        0, 32'h4, 1, 32'h400, 4));
      // 11: taken branch during flush -> squashed
      vecs.push_back(mk(32'h60, 1, 32'h60, 1, 0, 3'b000, 1, 0, 0, 32'h500, 32'h0, 0, 32'h64,
                        0, 32'h64, 0, 32'h400, 4));
      // 12: squashed branch left no BTB entry
      vecs.push_back(idle(32'h60, 0, 32'h64, 32'h400, 4));
      // 13: BLT not taken, predicted not taken -> no redirect; ctr 10->01
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 0, 3'b100, 0, 0, 0, 32'h400, 32'h0, 0, 32'h24,
                        1, 32'h400, 0, 32'h400, 4));
      // 14
      vecs.push_back(idle(32'h20, 0, 32'h24, 32'h400, 4));
      // 15: BGE taken (SIGN=0) -> redirect 0x440; ctr 01->10, target 0x440
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 0, 3'b101, 0, 0, 0, 32'h440, 32'h0, 0, 32'h24,
                        0, 32'h24, 1, 32'h440, 5));
      // 16
      vecs.push_back(idle(32'h20, 1, 32'h440, 32'h440, 5));
      // 17: BLTU taken, correctly predicted -> ctr 10->11
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 0, 3'b110, 0, 0, 1, 32'h440, 32'h0, 1, 32'h440,
                        1, 32'h440, 0, 32'h440, 5));
      // 18: BGEU not taken, predicted taken -> redirect 0x24; ctr 11->10
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 0, 3'b111, 0, 0, 1, 32'h440, 32'h0, 1, 32'h440,
                        1, 32'h440, 1, 32'h24, 6));
      // 19
      vecs.push_back(idle(32'h20, 1, 32'h440, 32'h24, 6));
      // 20: funct3 010 never taken even with all flags set; ctr 10->01
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 0, 3'b010, 1, 1, 1, 32'h440, 32'h0, 0, 32'h24,
                        1, 32'h440, 0, 32'h24, 6));
      // 21
      vecs.push_back(idle(32'h20, 0, 32'h24, 32'h24, 6));
      // 22: EX_VALID=0 taken branch -> ignored
      vecs.push_back(mk(32'h20, 0, 32'h20, 1, 0, 3'b000, 1, 0, 0, 32'h700, 32'h0, 0, 32'h24,
                        0, 32'h24, 0, 32'h24, 6));
      // 23: jump and branch both set -> jump target wins; count reaches max 7
      vecs.push_back(mk(32'h20, 1, 32'h80, 1, 1, 3'b000, 0, 0, 0, 32'h600, 32'h500, 1, 32'h600,
                        0, 32'h24, 1, 32'h500, 7));
      // 24
      vecs.push_back(idle(32'h80, 1, 32'h500, 32'h500, 7));
      // 25: further mispredict, count saturated
      vecs.push_back(mk(32'h80, 1, 32'h20, 1, 0, 3'b000, 1, 0, 0, 32'h460, 32'h0, 0, 32'h24,
                        1, 32'h500, 1, 32'h460, 7));
      // 26
      vecs.push_back(idle(32'h20, 1, 32'h460, 32'h460, 7));
      // 27: BNE taken with wrong predicted target, count holds
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 0, 3'b001, 0, 0, 0, 32'h480, 32'h0, 1, 32'h460,
                        1, 32'h460, 1, 32'h480, 7));
      // 28
      vecs.push_back(idle(32'h20, 1, 32'h480, 32'h480, 7));

      // --- reset state ---
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc_mux", {31'd0, pc_mux}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_redirect", redirect_addr, 32'h0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_pred_target", pred_target, 32'h104);
      rst_n = 1'b1;

      // --- table ---
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
         check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_ptg);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pc_mux", i), {31'd0, pc_mux}, {31'd0, vecs[i].e_pulse});
         check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_pulse});
         check($sformatf("v%0d_redirect", i), redirect_addr, vecs[i].e_redir);
         check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      end

      // --- reset asserted in the middle of a redirect pulse ---
      v = mk(32'h20, 1, 32'h20, 1, 0, 3'b000, 1, 0, 0, 32'h4A0, 32'h0, 0, 32'h24,
             0, 32'h0, 0, 32'h0, 0);
      drive(v);
      @(posedge clk);
      #1;
      check("mid_pulse_pc_mux", {31'd0, pc_mux}, 32'd1);
      check("mid_pulse_redirect", redirect_addr, 32'h4A0);
      v = idle(32'h20, 0, 32'h0, 32'h0, 0);
      drive(v);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_pc_mux", {31'd0, pc_mux}, 32'd0);
      check("rst_mid_flush", {31'd0, flush}, 32'd0);
      check("rst_mid_redirect", redirect_addr, 32'h0);
      check("rst_mid_count", 32'(count), 32'd0);
      check("rst_mid_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_mid_pred_target", pred_target, 32'h24);
      if_pc = 32'h80;
      #1;
      check("rst_mid_pred_taken_80", {31'd0, pred_taken}, 32'd0);
      check("rst_mid_pred_target_80", pred_target, 32'h84);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_pc_mux", {31'd0, pc_mux}, 32'd0);
      check("post_rst_pred_taken_80", {31'd0, pred_taken}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
